writeback_arbiter: RTL

// Writeback stage directly upstream of the 32x32 register file; owns its single write port.

---
 rtl/writeback_arbiter_pkg.sv | 27 ++
 rtl/writeback_arbiter_fifo.sv | 83 ++++++++
 rtl/writeback_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// writeback_arbiter_pkg
// Shared core types for the writeback stage and the LSU.
//   REG_ADDR_W : width of a register-file address (32 architectural regs)
//   XLEN       : datapath width
//   NUM_REGS   : number of architectural registers
//   wb_entry_t : one pending register write {rd, data}
//   reg_onehot : decodes a register address into a NUM_REGS-wide one-hot mask
// ---------------------------------------------------------------------------
package writeback_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;
   localparam int NUM_REGS   = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;

   // One-hot decode of a destination register, used to build hazard masks.
   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
      reg_onehot     = '0;
      reg_onehot[rd] = 1'b1;
   endfunction

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Circular buffer of DEPTH wb_entry_t records holding LSU results that lost
// arbitration for the register-file write port.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   push         : enqueue push_entry (ignored when full)
//   push_entry   : entry to enqueue
//   pop          : drop the head entry (ignored when empty)
//   head         : oldest entry
//   count        : number of stored entries
//   full, empty  : occupancy flags
//   entries      : raw storage, slot i of the circular buffer
//   entry_valid  : bit i set when slot i currently holds a queued entry
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// ---------------------------------------------------------------------------
module wb_fifo
   import writeback_arbiter_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  wb_entry_t             push_entry,
   input  logic                  pop,
   output wb_entry_t             head,
   output logic [CNT_W-1:0]      count,
   output logic                  full,
   output logic                  empty,
   output wb_entry_t [DEPTH-1:0] entries,
   output logic [DEPTH-1:0]      entry_valid
);

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping. A simultaneous push and pop leaves
   // the count unchanged while both pointers move forward one slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Payload storage carries no reset; occupancy alone decides what is live.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   // A slot is live when its distance from the read pointer, measured
   // modulo DEPTH, is smaller than the number of stored entries.
   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      logic [PTR_W-1:0] offset;
      assign offset         = PTR_W'(i) - rd_ptr;
      assign entry_valid[i] = (CNT_W'(offset) < count);
      assign entries[i]     = mem[i];
   end

endmodule

// File: rtl/writeback_arbiter.sv
// ---------------------------------------------------------------------------
// writeback_arbiter
// Owns the single write port of the 32x32 register file and merges the ALU
// result stream (highest priority, no backpressure) with the LSU result
// stream (valid/ready). LSU results that cannot be written immediately are
// parked in wb_fifo; decode sees their destinations through pending_mask.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data   : ALU result for this cycle
//   lsu_valid/lsu_rd/lsu_data   : offered LSU result
//   lsu_ready                   : LSU result accepted this cycle
//   reg_write/write_reg/write_data : register-file write port
//   pipe_stall                  : registered; upstream must hold alu_valid low
//   pending_mask                : bit r set when a queued entry targets r
// ---------------------------------------------------------------------------
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic [REG_ADDR_W-1:0] lsu_rd,
   input  logic [XLEN-1:0]       lsu_data,
   output logic                  reg_write,
   output logic [REG_ADDR_W-1:0] write_reg,
   output logic [XLEN-1:0]       write_data,
   output logic                  pipe_stall,
   output logic [NUM_REGS-1:0]   pending_mask
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   wb_entry_t             fifo_head;
   wb_entry_t             lsu_entry;
   wb_entry_t             win;
   wb_entry_t [DEPTH-1:0] fifo_entries;
   logic [DEPTH-1:0]      fifo_valid;
   logic [CNT_W-1:0]      fifo_count;
   logic [CNT_W-1:0]      next_count;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  win_valid;
   logic                  bypass;
   logic                  stall_q;
   logic [NUM_REGS-1:0]   queued_mask;

   assign lsu_entry = '{rd: lsu_rd, data: lsu_data};

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (fifo_push),
      .push_entry  (lsu_entry),
      .pop         (fifo_pop),
      .head        (fifo_head),
      .count       (fifo_count),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .entries     (fifo_entries),
      .entry_valid (fifo_valid)
   );

   // Readiness only looks at current occupancy, so a full buffer refuses new
   // results even in a cycle where it is draining its head.
   assign lsu_ready = !rst && !fifo_full;

   // Write-port arbitration: ALU first, then the oldest queued LSU result,
   // then a direct LSU bypass when nothing is queued. Nothing wins in reset.
   always_comb begin
      win_valid = 1'b0;
      win       = '0;
      fifo_pop  = 1'b0;
      bypass    = 1'b0;
      if (!rst) begin
         if (alu_valid) begin
            win_valid = 1'b1;
            win       = '{rd: alu_rd, data: alu_data};
         end else if (!fifo_empty) begin
            win_valid = 1'b1;
            win       = fifo_head;
            fifo_pop  = 1'b1;
         end else if (lsu_valid) begin
            win_valid = 1'b1;
            win       = lsu_entry;
            bypass    = 1'b1;
         end
      end
   end

   // Any accepted LSU result that did not go straight to the register file
   // has to wait its turn in the buffer.
   assign fifo_push = lsu_valid && lsu_ready && !bypass;

   // x0 is hardwired to zero, so a winning rd of 0 is consumed silently and
   // the write port is parked at all-zeros whenever it is idle.
   always_comb begin
      reg_write  = win_valid && (win.rd != '0);
      write_reg  = reg_write ? win.rd   : '0;
      write_data = reg_write ? win.data : '0;
   end

   // Stall is raised one entry before the buffer is full, giving the ALU
   // result already in flight in the rising cycle somewhere to go.
   assign next_count = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= 1'b0;
      end else begin
         stall_q <= (next_count >= CNT_W'(DEPTH - 1));
      end
   end

   assign pipe_stall = stall_q && !rst;

   // Hazard mask covers queued entries only; bypassed and ALU writes land in
   // the register file the same cycle and never need to be waited on.
   always_comb begin
      queued_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (fifo_valid[i]) begin
            queued_mask = queued_mask | reg_onehot(fifo_entries[i].rd);
         end
      end
      queued_mask[0] = 1'b0;
   end

   assign pending_mask = rst ? '0 : queued_mask;

   // Upstream may still present one ALU result in the cycle stall rises, but
   // never once stall has been visible for a full cycle.
   assert property (@(posedge clk) disable iff (rst)
      (pipe_stall && $past(pipe_stall)) |-> !alu_valid)
      else $error("alu_valid asserted while pipe_stall held");

   // An offered LSU result should stay offered until it is taken.
   assert property (@(posedge clk) disable iff (rst)
      (lsu_valid && !lsu_ready) |=> lsu_valid)
      else $warning("lsu_valid withdrawn before handshake");

endmodule
